lcd_bus_ctrl: RTL

Parametrised HD44780 bus driver that supersedes the fixed 4-bit nibble sender: it buffers character/command writes in a small FIFO and drives RS/E/DB in 4-bit or 8-bit bus mode. It inserts a per-transfer settle time: short for ordinary writes, long for clear/home commands. It also supports single-nibble transfers for the power-on init sequence. It sits between the display-content sequencer and the LCD pins.

---
 rtl/lcd_bus_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_ctrl.sv
// rtl/lcd_bus_ctrl.sv - HD44780 RS/E/DB driver with command FIFO, 4/8-bit strobes and settle waits
module lcd_bus_ctrl #(
  parameter int BUS_WIDTH         = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter int SETUP_CYCLES      = 1,
  parameter int EN_HIGH_CYCLES    = 4,
  parameter int SHORT_WAIT_CYCLES = 600,
  parameter int LONG_WAIT_CYCLES  = 18300
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_rs,
  input  logic [7:0]           wr_data,
  input  logic                 wr_nibble_only,
  output logic                 full,
  output logic                 busy,
  output logic                 overflow,
  output logic                 rs_out,
  output logic                 enable_out,
  output logic [BUS_WIDTH-1:0] data_out
);
  // BUS_WIDTH must be 4 or 8; FIFO_DEPTH a power of two >= 2.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LONG_WAIT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HIGH, S_EN_LOW, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [9:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           cur_rs_q, cur_rs_d, cur_nib_q, cur_nib_d, low_phase_q, low_phase_d;
  logic [7:0]     cur_byte_q, cur_byte_d;
  logic           rs_out_q, rs_out_d, enable_q, enable_d;
  logic [BUS_WIDTH-1:0] data_out_q, data_out_d;
  logic           empty, push, pop, long_wait;

  // Full/empty come from the registered count, so they reflect the state before any same-cycle pop.
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wr_en & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign busy      = ~empty | (state_q != S_IDLE);
  assign overflow  = overflow_q;
  assign rs_out    = rs_out_q;
  assign enable_out = enable_q;
  assign data_out  = data_out_q;
  assign long_wait = ~cur_rs_q & ~cur_nib_q &
                     ((cur_byte_q == 8'h01) | (cur_byte_q == 8'h02) | (cur_byte_q == 8'h03));

  // Command FIFO bookkeeping and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (wr_en & full);
    if (push) begin
      mem_d[wr_ptr_q] = {wr_nibble_only, wr_rs, wr_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Strobe sequencer: every state entry reloads the single down-counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_rs_d    = cur_rs_q;
    cur_byte_d  = cur_byte_q;
    cur_nib_d   = cur_nib_q;
    low_phase_d = low_phase_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cur_nib_d   = (BUS_WIDTH == 4) ? mem_q[rd_ptr_q][9] : 1'b0;
          cur_rs_d    = mem_q[rd_ptr_q][8];
          cur_byte_d  = mem_q[rd_ptr_q][7:0];
          low_phase_d = 1'b0;
          state_d     = S_SETUP;
          cnt_d       = CW'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EN_HIGH;
          cnt_d   = CW'(EN_HIGH_CYCLES - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_EN_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_EN_LOW;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_EN_LOW: begin
        if ((BUS_WIDTH == 4) && !low_phase_q && !cur_nib_q) begin
          low_phase_d = 1'b1;
          state_d     = S_SETUP;
          cnt_d       = CW'(SETUP_CYCLES - 1);
        end else begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? CW'(LONG_WAIT_CYCLES - 1) : CW'(SHORT_WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values follow the current state one cycle later; RS/DB only move in SETUP, so never under E.
  always_comb begin
    rs_out_d   = rs_out_q;
    data_out_d = data_out_q;
    enable_d   = (state_q == S_EN_HIGH);
    if (state_q == S_SETUP) begin
      rs_out_d   = cur_rs_q;
      data_out_d = low_phase_q ? cur_byte_q[BUS_WIDTH-1:0] : cur_byte_q[7 -: BUS_WIDTH];
    end
  end

  // All state and pin registers; reset aborts any transfer and discards queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cur_rs_q    <= 1'b0;
      cur_byte_q  <= '0;
      cur_nib_q   <= 1'b0;
      low_phase_q <= 1'b0;
      rs_out_q    <= 1'b0;
      enable_q    <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cur_rs_q    <= cur_rs_d;
      cur_byte_q  <= cur_byte_d;
      cur_nib_q   <= cur_nib_d;
      low_phase_q <= low_phase_d;
      rs_out_q    <= rs_out_d;
      enable_q    <= enable_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule
